// File: rtl/bcd_decimal_decoder.sv
// BCD-to-decimal decoder with valid/ready input and timed one-hot outputs.
// A BCD digit {A,B,C,D} is accepted when in_valid && in_ready. A legal digit
// (0..9) drives exactly one of E0..E9 for HOLD_CYCLES cycles, starting one
// cycle after acceptance. An illegal code (10..15) gives a one-cycle err pulse
// and bumps a saturating err_count. No new digit is taken while a line is shown.
//
// Ports:
//   clk, rst_n        clock (rising edge) and async active-low reset
//   in_valid/in_ready input handshake; in_ready is high only when idle
//   A,B,C,D           BCD digit, A is the MSB
//   E0..E9            registered one-hot decimal lines
//   out_valid         high while any E line is high
//   err               one-cycle pulse after an illegal code is accepted
//   err_count         saturating count of illegal codes
module bcd_decimal_decoder #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             D,
   output logic             E0,
   output logic             E1,
   output logic             E2,
   output logic             E3,
   output logic             E4,
   output logic             E5,
   output logic             E6,
   output logic             E7,
   output logic             E8,
   output logic             E9,
   output logic             out_valid,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned LINES   = 10;
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   // Reject out-of-range parameters at elaboration.
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("bcd_decimal_decoder: HOLD_CYCLES must be in 1..255");
   end
   if (ERR_W < 1) begin : g_bad_err_w
      $error("bcd_decimal_decoder: ERR_W must be at least 1");
   end

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t               state;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [LINES-1:0]     lines;
   logic [DIGIT_W-1:0]   code;
   logic                 take;

   assign code     = {A, B, C, D};
   assign in_ready = (state == IDLE);
   assign take     = in_valid && in_ready;

   // Controller: accept, display for HOLD_CYCLES cycles, then release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         lines     <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  if (code <= 4'd9) begin
                     lines     <= LINES'(1) << code;
                     out_valid <= 1'b1;
                     // First display cycle is already counted by the transfer edge.
                     hold_cnt  <= HOLD_W'(HOLD_CYCLES - 1);
                     state     <= HOLD;
                  end else begin
                     err <= 1'b1;
                     if (err_count != ERR_MAX) begin
                        err_count <= err_count + ERR_W'(1);
                     end
                  end
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  lines     <= '0;
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            default: begin
               lines     <= '0;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign E0 = lines[0];
   assign E1 = lines[1];
   assign E2 = lines[2];
   assign E3 = lines[3];
   assign E4 = lines[4];
   assign E5 = lines[5];
   assign E6 = lines[6];
   assign E7 = lines[7];
   assign E8 = lines[8];
   assign E9 = lines[9];

endmodule

// File: tb/tb_bcd_decimal_decoder.sv
// Bench for bcd_decimal_decoder: three instances share one stimulus stream
//   u0: HOLD_CYCLES=4, ERR_W=8   u1: HOLD_CYCLES=4, ERR_W=2   u2: HOLD_CYCLES=1, ERR_W=8
// A cycle-count model predicts every output of every instance; directed
// literal expectations pin the model at key points.
module tb_bcd_decimal_decoder;

   localparam int unsigned N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic [3:0] digit = 4'd0;
   logic chk_en = 1'b0;

   logic [9:0] e    [N];
   logic       ov   [N];
   logic       rdy  [N];
   logic       er   [N];
   logic [7:0] errc [N];

   int vectors = 0;
   int miscompares = 0;

   // Model state: cycles of display left, shown digit, error pulse, error count.
   int m_rem   [N] = '{0, 0, 0};
   int m_digit [N] = '{0, 0, 0};
   int m_err   [N] = '{0, 0, 0};
   int m_errc  [N] = '{0, 0, 0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int unsigned H = (g == 2) ? 1 : 4;
      localparam int unsigned W = (g == 1) ? 2 : 8;
      logic [W-1:0] cnt;
      logic [9:0]   ev;
      logic         ovl, rdl, erl;
      bcd_decimal_decoder #(.HOLD_CYCLES(H), .ERR_W(W)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdl),
         .A(digit[3]), .B(digit[2]), .C(digit[1]), .D(digit[0]),
         .E0(ev[0]), .E1(ev[1]), .E2(ev[2]), .E3(ev[3]), .E4(ev[4]),
         .E5(ev[5]), .E6(ev[6]), .E7(ev[7]), .E8(ev[8]), .E9(ev[9]),
         .out_valid(ovl), .err(erl), .err_count(cnt)
      );
      assign e[g]    = ev;
      assign ov[g]   = ovl;
      assign rdy[g]  = rdl;
      assign er[g]   = erl;
      assign errc[g] = 8'(cnt);
   end

   function automatic int hold_of(input int i);
      return (i == 2) ? 1 : 4;
   endfunction

   function automatic int errmax_of(input int i);
      return (i == 1) ? 3 : 255;
   endfunction

   task automatic cmp(input string name, input int inst, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s[u%0d] @%0t: got 0x%0h expected 0x%0h", name, inst, $time, act, exp);
      end
   endtask

   // Model: a legal digit seen while idle is displayed for exactly H cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_rem[i] = 0; m_digit[i] = 0; m_err[i] = 0; m_errc[i] = 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            m_err[i] = 0;
            if (m_rem[i] == 0 && in_valid) begin
               if (int'(digit) < 10) begin
                  m_rem[i]   = hold_of(i);
                  m_digit[i] = int'(digit);
               end else begin
                  m_err[i] = 1;
                  if (m_errc[i] < errmax_of(i)) m_errc[i] = m_errc[i] + 1;
               end
            end else if (m_rem[i] > 0) begin
               m_rem[i] = m_rem[i] - 1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < N; i++) begin
            cmp("e", i, int'(e[i]), (m_rem[i] > 0) ? (1 << m_digit[i]) : 0);
            cmp("out_valid", i, int'(ov[i]), (m_rem[i] > 0) ? 1 : 0);
            cmp("in_ready", i, int'(rdy[i]), (m_rem[i] == 0) ? 1 : 0);
            cmp("err", i, int'(er[i]), m_err[i]);
            cmp("err_count", i, int'(errc[i]), m_errc[i]);
            cmp("onehot", i, ($countones(e[i]) <= 1) ? 1 : 0, 1);
            cmp("ov_is_or", i, int'(ov[i]), int'(|e[i]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // Reset and reset-state literals.
      tick();
      chk_en = 1'b1;
      tick();
      #1 rst_n = 1'b1;
      tick();
      cmp("rst_e", 0, int'(e[0]), 0);
      cmp("rst_ov", 0, int'(ov[0]), 0);
      cmp("rst_rdy", 0, int'(rdy[0]), 1);
      cmp("rst_errc", 0, int'(errc[0]), 0);

      // Single digit 5 for one cycle.
      in_valid = 1'b1; digit = 4'd5;
      tick();
      in_valid = 1'b0;
      cmp("t1_e5", 0, int'(e[0]), 10'b00_0010_0000);
      cmp("t1_ov", 0, int'(ov[0]), 1);
      cmp("t1_rdy", 0, int'(rdy[0]), 0);
      repeat (3) tick();
      cmp("t1_e5_last", 0, int'(e[0]), 10'b00_0010_0000);
      tick();
      cmp("t1_e_off", 0, int'(e[0]), 0);
      cmp("t1_rdy_back", 0, int'(rdy[0]), 1);

      // Sweep 0..9 with in_valid held high; transfers five cycles apart.
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         digit = 4'(k);
         tick();
         cmp("t2_sweep", 0, int'(e[0]), 1 << k);
         repeat (4) tick();
      end

      // Back-to-back illegal codes.
      digit = 4'd10;
      tick();
      cmp("t3_err1", 0, int'(er[0]), 1);
      cmp("t3_cnt1", 0, int'(errc[0]), 1);
      digit = 4'd15;
      tick();
      cmp("t3_err2", 0, int'(er[0]), 1);
      cmp("t3_cnt2", 0, int'(errc[0]), 2);
      cmp("t3_e", 0, int'(e[0]), 0);
      cmp("t3_rdy", 0, int'(rdy[0]), 1);
      in_valid = 1'b0;
      tick();
      cmp("t3_err_drop", 0, int'(er[0]), 0);

      // Saturation of a 2-bit counter.
      do_reset();
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         digit = 4'(11 + k);
         tick();
         cmp("t4_cnt_w2", 1, int'(errc[1]), (k < 3) ? k + 1 : 3);
         cmp("t4_cnt_w8", 0, int'(errc[0]), k + 1);
      end
      in_valid = 1'b0;
      tick();

      // Asynchronous reset during the second hold cycle.
      in_valid = 1'b1; digit = 4'd7;
      tick();
      in_valid = 1'b0;
      cmp("t5_e7", 0, int'(e[0]), 10'b00_1000_0000);
      tick();
      #1 rst_n = 1'b0;
      #1;
      cmp("t5_async_e", 0, int'(e[0]), 0);
      cmp("t5_async_ov", 0, int'(ov[0]), 0);
      cmp("t5_async_rdy", 0, int'(rdy[0]), 1);
      tick();
      #1 rst_n = 1'b1;
      in_valid = 1'b1; digit = 4'd0;
      tick();
      in_valid = 1'b0;
      cmp("t5_e0", 0, int'(e[0]), 1);
      cmp("t5_ov", 0, int'(ov[0]), 1);
      repeat (4) tick();

      // HOLD_CYCLES=1 stream: one cycle on, one cycle gap, one cycle on.
      do_reset();
      in_valid = 1'b1; digit = 4'd1;
      tick();
      cmp("t6_e1", 2, int'(e[2]), 10'b00_0000_0010);
      cmp("t6_rdy0", 2, int'(rdy[2]), 0);
      digit = 4'd2;
      tick();
      cmp("t6_gap_e", 2, int'(e[2]), 0);
      cmp("t6_gap_rdy", 2, int'(rdy[2]), 1);
      tick();
      in_valid = 1'b0;
      cmp("t6_e2", 2, int'(e[2]), 10'b00_0000_0100);
      tick();
      cmp("t6_off", 2, int'(e[2]), 0);
      repeat (6) tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bcd_decimal_decoder.md
Name: bcd_decimal_decoder

Overview:
- Inverse of the decimal-to-BCD encoder: accepts one 4-bit BCD digit at a time on a valid/ready handshake and drives exactly one of ten one-hot decimal lines E0..E9.
- Registered output, held for a fixed number of cycles; illegal codes (10..15) are rejected and counted.
- Used to drive decimal indicator/select lines from BCD producers (the encoder, counters, keypads).

Parameters:
HOLD_CYCLES, 4, cycles each decoded line stays asserted; legal range 1..255; 0 is illegal (elaboration error)
ERR_W, 8, width of the saturating illegal-code counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  BCD digit on A,B,C,D is valid
in_ready  output  1  block can accept a digit this cycle
A  input  1  BCD bit 3 (MSB)
B  input  1  BCD bit 2
C  input  1  BCD bit 1
D  input  1  BCD bit 0 (LSB)
E0..E9  output  1 each  one-hot decimal lines; Ek=1 means digit k
out_valid  output  1  high while an E line is asserted
err  output  1  one-cycle pulse on acceptance of code 10..15
err_count  output  ERR_W  saturating count of rejected codes

Behaviour:
- Reset (rst_n=0, async, any time): state=IDLE, E0..E9=0, out_valid=0, err=0, err_count=0, hold counter=0. in_ready is combinational from state, so it is 1 immediately.
- in_ready = 1 in IDLE, 0 in HOLD. Transfer occurs on a rising edge with in_valid && in_ready. A,B,C,D are sampled only on a transfer and ignored otherwise.
- IDLE, transfer with code 0..9:
  - Next cycle: E[code]=1, all other E=0, out_valid=1.
  - Hold counter = HOLD_CYCLES-1; state goes to HOLD.
  - Latency is 1 cycle, input edge to output.
- IDLE, transfer with code 10..15:
  - Next cycle: err=1 for exactly one cycle; E0..E9=0; out_valid=0.
  - err_count increments, saturating at 2^ERR_W-1 (never wraps).
  - State stays IDLE and in_ready stays 1, so back-to-back illegal codes give consecutive err pulses and +1 per cycle.
- HOLD:
  - E and out_valid are held constant; the counter decrements each cycle.
  - On the cycle the counter is 0, the next edge clears E0..E9 and out_valid and returns to IDLE.
  - Net result: out_valid is high for exactly HOLD_CYCLES cycles.
- Throughput: after a legal digit, the next transfer is possible no earlier than HOLD_CYCLES+1 cycles after the previous one. No input buffering.
- in_valid may stay high across HOLD; the digit is accepted on the first IDLE edge.
- Invariant: at most one E line is high at any time. out_valid = OR(E0..E9).
- Reset asserted mid-HOLD: outputs clear immediately (async); after release, the block is in IDLE with ready=1.
- HOLD_CYCLES=1: out_valid is high for exactly 1 cycle, followed by a 1-cycle IDLE gap.

Test Plan:
1. Reset, then release; send ABCD=0101 for one cycle -> next cycle E5=1, out_valid=1 for 4 cycles, in_ready=0 during those cycles, then everything returns to 0 and ready=1.
2. Sweep codes 0..9 with in_valid held high -> each Ek asserted in order for 4 cycles; one-hot invariant checked every cycle; transfers are 5 cycles apart.
3. Send 1010, then 1111 on consecutive cycles -> err pulses on 2 consecutive cycles; err_count=2; E all 0; ready stays 1.
4. ERR_W=2; send 5 illegal codes -> err_count reads 1,2,3,3,3 (saturates).
5. Send 0111, pull rst_n low during the 2nd hold cycle -> E7 and out_valid drop without waiting for a clock edge; after release, send 0000 -> E0 asserted 1 cycle later.
6. HOLD_CYCLES=1; stream 0001,0010 -> E1 for 1 cycle, 1-cycle gap, then E2 for 1 cycle.
